// File: rtl/ad_sample_packer.sv
// ad_sample_packer: packs 16-bit AD7606 sample pairs into 32-bit words and queues them in a FWFT FIFO
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   smp_valid/data/first  : sample strobe, sample value, first-of-conversion flag
//   req_vaild/req_ready   : FIFO non-empty / consumer accepts head word
//   r_in                  : head word {second, first}, 0 when empty
//   fifo_level            : words stored
//   overflow_cnt          : saturating count of words dropped on a full FIFO
module ad_sample_packer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       smp_valid,
  input  logic [15:0]                smp_data,
  input  logic                       smp_first,
  output logic                       req_vaild,
  input  logic                       req_ready,
  output logic [31:0]                r_in,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [CNT_W-1:0]           overflow_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {HALF_EMPTY, HALF_FULL} state_t;
  state_t state;
  logic [15:0] low;
  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic push, pop, full, empty, accept, drop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr - rd_ptr) == (AW+1)'(DEPTH);
  assign push = smp_valid & (state == HALF_FULL) & ~smp_first;
  assign pop = ~empty & req_ready;
  // a pop in the same cycle frees the slot, so a push at full is still taken
  assign accept = push & (~full | pop);
  assign drop = push & full & ~pop;
  assign wr_nxt = accept ? wr_ptr + (AW+1)'(1) : wr_ptr;
  assign rd_nxt = pop ? rd_ptr + (AW+1)'(1) : rd_ptr;
  assign req_vaild = ~empty;
  assign r_in = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk)
    if (accept) mem[wr_ptr[AW-1:0]] <= {smp_data, low};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HALF_EMPTY;
      low <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      overflow_cnt <= '0;
    end else begin
      if (smp_valid) begin
        // a first-flagged sample always restarts the pair, discarding any held half
        low <= (state == HALF_EMPTY || smp_first) ? smp_data : low;
        state <= (state == HALF_FULL && !smp_first) ? HALF_EMPTY : HALF_FULL;
      end
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      fifo_level <= wr_nxt - rd_nxt;
      if (drop && overflow_cnt != '1) overflow_cnt <= overflow_cnt + CNT_W'(1);
    end
  end
endmodule
